// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encoding, flag bit
// positions and controller states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier returning the low WIDTH bits of a*b.
// One partial product per cycle; done holds until ack so the result survives a stall.
module alu_mul_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ack,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q && (cnt_q != CNT_W'(WIDTH))) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end else if (busy_q && ack) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign done    = busy_q && (cnt_q == CNT_W'(WIDTH));
    assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready handshakes and a one-entry output register.
// MUL goes through an iterative multiplier while the controller sits in BUSY.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic             ready_en_q, ready_en_d;

    logic             accept;
    logic             is_mul;
    logic             mul_start, mul_ack, mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH:0]   add_full, sub_full;
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_err;
    logic [3:0]       alu_flags;

    // ready_en_q keeps in_ready low during reset and lifts it on the first edge after release.
    assign ready_en_d = 1'b1;
    assign in_ready   = ready_en_q && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign is_mul     = MUL_EN && (op == OP_MUL);

    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_err  = 1'b0;
        add_full = {1'b0, a} + {1'b0, b};
        sub_full = {1'b0, a} - {1'b0, b};
        sh       = b[SH_W-1:0];
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
            end
            OP_SLL:  alu_res = a << sh;
            OP_SRL:  alu_res = a >> sh;
            OP_SRA:  alu_res = $signed(a) >>> sh;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_MUL:  alu_err = !MUL_EN;
            default: alu_err = 1'b1;
        endcase
        alu_flags = '0;
        if (!alu_err) begin
            alu_flags[FLAG_Z] = (alu_res == '0);
            alu_flags[FLAG_N] = alu_res[MSB];
            alu_flags[FLAG_C] = alu_c;
            alu_flags[FLAG_V] = alu_v;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        err_d       = err_q;
        mul_start   = 1'b0;
        mul_ack     = 1'b0;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        mul_start = 1'b1;
                        state_d   = ST_BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        flags_d     = alu_flags;
                        err_d       = alu_err;
                    end
                end
            end
            ST_BUSY: begin
                // Finished product waits in the multiplier until the output slot frees up.
                if (mul_done && (!out_valid_q || out_ready)) begin
                    mul_ack         = 1'b1;
                    state_d         = ST_IDLE;
                    out_valid_d     = 1'b1;
                    result_d        = mul_product;
                    flags_d         = '0;
                    flags_d[FLAG_Z] = (mul_product == '0);
                    flags_d[FLAG_N] = mul_product[MSB];
                    err_d           = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            ready_en_q  <= ready_en_d;
        end
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(
                .WIDTH (WIDTH)
            ) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .a       (a),
                .b       (b),
                .ack     (mul_ack),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases plus randomized traffic
// against a plain-arithmetic reference model, with random output back-pressure.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         err;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         er;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   rdy_mode = 0;

    alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, expv);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic [3:0] f, input logic e);
        exp_t x;
        x.res = r;
        x.flg = f;
        x.er  = e;
        return x;
    endfunction

    // Reference model: plain arithmetic on wider signed/unsigned values.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [W:0] wide;
        logic signed [W:0] sw;
        logic [W-1:0] r;
        int sh;
        e = '0;
        sh = int'(y[5:0]);
        case (o)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: begin
                wide = {1'b0, x} + {1'b0, y};
                e.res = wide[W-1:0];
                e.flg[FLAG_C] = wide[W];
                sw = $signed({x[W-1], x}) + $signed({y[W-1], y});
                e.flg[FLAG_V] = (sw[W] != sw[W-1]);
            end
            4'd3: begin
                e.res = x - y;
                e.flg[FLAG_C] = (x < y);
                sw = $signed({x[W-1], x}) - $signed({y[W-1], y});
                e.flg[FLAG_V] = (sw[W] != sw[W-1]);
            end
            4'd4: e.res = x ^ y;
            4'd5: e.res = x << sh;
            4'd6: e.res = x >> sh;
            4'd7: begin
                r = x;
                for (int i = 0; i < sh; i++) r = {x[W-1], r[W-1:1]};
                e.res = r;
            end
            4'd8: e.res = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            4'd9: e.res = (x < y) ? 64'd1 : 64'd0;
            4'd10: e.res = x * y;
            default: begin
                e.er = 1'b1;
                return e;
            end
        endcase
        e.flg[FLAG_Z] = (e.res == 0);
        e.flg[FLAG_N] = e.res[W-1];
        return e;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 64'h0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called at posedge+1; returns at acceptance edge+1 with in_valid dropped.
    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input exp_t e, output int waited);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 500) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got=no_accept expected=accept op=%0d", o);
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("sent op=%0d a=%h b=%h waited=%0d", o, x, y, waited);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, and checks hold stability during stalls.
    initial begin
        exp_t e;
        logic held_v;
        logic [W+4:0] held;
        held_v = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("stall_stable", {out_valid, result, flags, err}, {1'b1, held});
                end
                if (out_valid && !out_ready) begin
                    held_v = 1'b1;
                    held = {result, flags, err};
                end else begin
                    held_v = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got=%h expected=none", result);
                    end else begin
                        e = exp_q.pop_front();
                        check("scoreboard", {result, flags, err}, {e.res, e.flg, e.er});
                        $display("recv result=%h flags=%b err=%b", result, flags, err);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, w1, w2, cyc;
        logic ready_seen, valid_seen;
        logic [3:0] o;
        logic [W-1:0] x, y;

        rst_n = 1'b0;
        in_valid = 1'b0;
        op = 4'd0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, in_ready, err, flags, result}, '0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("in_ready_after_release", in_ready, 1'b1);

        send(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, mk(64'd0, 4'b0101, 1'b0), w0);
        check("add_latency", out_valid, 1'b1);
        send(OP_SUB, 64'h8000_0000_0000_0000, 64'd1, mk(64'h7FFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0), w0);
        send(OP_SRA, 64'h8000_0000_0000_0000, 64'h43, mk(64'hF000_0000_0000_0000, 4'b0010, 1'b0), w0);

        send(OP_MUL, 64'd7, 64'd6, mk(64'd42, 4'b0000, 1'b0), w0);
        ready_seen = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            cyc = i;
            if (out_valid) break;
            if (in_ready) ready_seen = 1'b1;
        end
        check("mul_latency", cyc, 65);
        check("mul_in_ready_busy", ready_seen, 1'b0);

        send(OP_ADD, 64'd1, 64'd1, mk(64'd2, 4'b0000, 1'b0), w0);
        send(OP_ADD, 64'd2, 64'd2, mk(64'd4, 4'b0000, 1'b0), w1);
        send(OP_ADD, 64'd3, 64'd3, mk(64'd6, 4'b0000, 1'b0), w2);
        check("b2b_no_bubble", w0 + w1 + w2, 0);
        rdy_mode = 2;
        @(posedge clk);
        #1;
        check("stall_result", {out_valid, result}, {1'b1, 64'd6});
        repeat (2) @(posedge clk);
        #1;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_drained", exp_q.size(), 0);

        send(OP_MUL, {$urandom, $urandom}, {$urandom, $urandom}, mk(64'd0, 4'b0000, 1'b0), w0);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_reset_state", {out_valid, in_ready}, 2'b00);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_in_ready_before_edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("abort_in_ready_after_edge", in_ready, 1'b1);
        valid_seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) valid_seen = 1'b1;
        end
        check("abort_no_valid", valid_seen, 1'b0);
        send(4'hC, {$urandom, $urandom}, {$urandom, $urandom}, mk(64'd0, 4'b0000, 1'b1), w0);
        check("illegal_direct", {out_valid, err, flags, result}, {1'b1, 1'b1, 4'b0000, 64'd0});

        rdy_mode = 1;
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 5) o = 4'd10;
            else if (r < 12) o = 4'($urandom_range(11, 15));
            else o = 4'($urandom_range(0, 9));
            x = rand_operand();
            y = rand_operand();
            send(o, x, y, model(o, x, y), w0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        rdy_mode = 0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("final_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
